// File: rtl/lfsr_9bit.sv
// ---------------------------------------------------------------------------
// lfsr_9bit
//
// Free-running 9-bit maximal-length XNOR Fibonacci LFSR. It supplies the
// pseudo-random value that the computer player of the Tug-of-War game
// compares against its difficulty threshold.
//
// Polynomial x^9 + x^5 + 1 in XNOR form. The sequence has a period of
// 511 states. All-ones (9'h1FF) is the single lock-up state and is never
// entered.
//
// Optional feature (compile-time macro LFSR_PERIOD_TRACK_EN):
//   Adds period tracking. step_count counts enabled steps since the last
//   start point, which is RESET_VALUE after reset or the effective seed
//   after a load. period_wrap pulses for one cycle, aligned with Q, when Q
//   returns to the start point.
//
// Parameters:
//   RESET_VALUE  state loaded on reset (must not be 9'h1FF)
//
// Ports:
//   clk          in   system clock, all logic on the rising edge
//   reset        in   synchronous active-low reset
//   en           in   step enable, 1 = advance one state per cycle
//   load         in   synchronous seed-load strobe (overrides en)
//   seed         in   [8:0] seed value for load
//   Q            out  [8:0] current LFSR state (registered)
//   period_wrap  out  one-cycle wrap pulse      (LFSR_PERIOD_TRACK_EN only)
//   step_count   out  [8:0] steps since start    (LFSR_PERIOD_TRACK_EN only)
// ---------------------------------------------------------------------------
module lfsr_9bit #(
    parameter logic [8:0] RESET_VALUE = 9'h000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       load,
    input  logic [8:0] seed,
    output logic [8:0] Q
`ifdef LFSR_PERIOD_TRACK_EN
    ,
    output logic       period_wrap,
    output logic [8:0] step_count
`endif
);

    localparam logic [8:0] LOCKUP = 9'h1FF;

    logic [8:0] next_q;    // state after one enabled step
    logic [8:0] seed_eff;  // seed with the lock-up value replaced

    // NOTE: every signal driven here gets a value on every path, so no
    // latch is inferred; use blocking '=' in combinational blocks.
    always_comb begin
        next_q   = {Q[7:0], ~(Q[8] ^ Q[4])};
        seed_eff = seed;
        // The XNOR form stalls forever in all-ones; step out of it to zero.
        if (Q == LOCKUP) begin
            next_q = 9'h000;
        end
        if (seed == LOCKUP) begin
            seed_eff = 9'h000;
        end
    end

    // Priority: reset > load > en > hold.
    // NOTE: sequential state uses non-blocking '<=' so every register
    // samples the values from before the edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            Q <= RESET_VALUE;
        end else if (load) begin
            Q <= seed_eff;
        end else if (en) begin
            Q <= next_q;
        end
    end

`ifdef LFSR_PERIOD_TRACK_EN
    logic [8:0] start_point;  // value Q held when the current period began

    // The wrap is detected on the step that lands back on the start point,
    // so the registered pulse lines up with Q showing that value. The
    // counter clears on that same edge, so it reads 0 during the pulse.
    always_ff @(posedge clk) begin
        if (!reset) begin
            start_point <= RESET_VALUE;
            step_count  <= 9'd0;
            period_wrap <= 1'b0;
        end else if (load) begin
            start_point <= seed_eff;
            step_count  <= 9'd0;
            period_wrap <= 1'b0;
        end else if (en) begin
            if (next_q == start_point) begin
                step_count  <= 9'd0;
                period_wrap <= 1'b1;
            end else begin
                step_count  <= step_count + 9'd1;
                period_wrap <= 1'b0;
            end
        end else begin
            period_wrap <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_lfsr_9bit.sv
// ---------------------------------------------------------------------------
// tb_lfsr_9bit
//
// Self-checking bench for lfsr_9bit. A reference model computes each next
// state from the polynomial rule with integer arithmetic. The bench also
// tracks the period start point and step count independently of the design.
// Directed steps run first, followed by a randomized mix of reset, load and
// enable activity.
// ---------------------------------------------------------------------------
module tb_lfsr_9bit;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic       load;
    logic [8:0] seed;
    logic [8:0] Q;
`ifdef LFSR_PERIOD_TRACK_EN
    logic       period_wrap;
    logic [8:0] step_count;
`endif

    always #5 clk = ~clk;

    lfsr_9bit dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .load        (load),
        .seed        (seed),
        .Q           (Q)
`ifdef LFSR_PERIOD_TRACK_EN
        ,
        .period_wrap (period_wrap),
        .step_count  (step_count)
`endif
    );

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int m_q;
    int m_start;
    int m_cnt;
    int m_wrap;

    // Next value from the rule: double the state modulo 512, then add 1
    // when bit 8 and bit 4 are equal (XNOR feedback). All-ones goes to zero.
    function automatic int ref_next(input int v);
        int fb;
        if (v == 511) return 0;
        fb = (((v / 256) % 2) == ((v / 16) % 2)) ? 1 : 0;
        return ((v * 2) % 512) + fb;
    endfunction

    task automatic check9(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, advance the model, then compare after the edge.
    task automatic cycle(input logic r, input logic l, input logic e, input logic [8:0] s,
                         input string tag);
        reset = r;
        load  = l;
        en    = e;
        seed  = s;
        if (!r) begin
            m_q = 0; m_start = 0; m_cnt = 0; m_wrap = 0;
        end else if (l) begin
            m_q = (s == 9'h1FF) ? 0 : int'(s);
            m_start = m_q; m_cnt = 0; m_wrap = 0;
        end else if (e) begin
            m_q = ref_next(m_q);
            m_cnt++;
            if (m_q == m_start) begin
                m_wrap = 1; m_cnt = 0;
            end else begin
                m_wrap = 0;
            end
        end else begin
            m_wrap = 0;
        end
        @(posedge clk);
        #1;
        check9(tag, Q, m_q[8:0]);
`ifdef LFSR_PERIOD_TRACK_EN
        check9({tag, "_wrap"}, {8'd0, period_wrap}, m_wrap[8:0]);
        check9({tag, "_cnt"}, step_count, m_cnt[8:0]);
`endif
    endtask

    logic [8:0] exp_seq [6];
    logic       seen [512];
    logic [8:0] held;

    initial begin
        exp_seq[0] = 9'h001; exp_seq[1] = 9'h003; exp_seq[2] = 9'h007;
        exp_seq[3] = 9'h00F; exp_seq[4] = 9'h01F; exp_seq[5] = 9'h03E;
        reset = 1'b0; load = 1'b0; en = 1'b0; seed = 9'h000;
        m_q = 0; m_start = 0; m_cnt = 0; m_wrap = 0;
        @(posedge clk);
        #1;

        // Reset state, then the documented opening sequence.
        cycle(1'b0, 1'b0, 1'b1, 9'h000, "reset");
        check9("reset_const", Q, 9'h000);
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, 1'b0, 1'b1, 9'h000, "seq");
            check9("seq_const", Q, exp_seq[i]);
        end

        // Full period: 600 steps from reset, all distinct within the period.
        cycle(1'b0, 1'b0, 1'b0, 9'h000, "reset2");
        for (int i = 0; i < 512; i++) seen[i] = 1'b0;
        seen[0] = 1'b1;
        for (int i = 1; i <= 600; i++) begin
            cycle(1'b1, 1'b0, 1'b1, 9'h000, "period");
            if (Q === 9'h1FF) check9("never_1ff", Q, 9'h000);
            if (i < 511) begin
                check9("unique", {8'd0, seen[Q]}, 9'd0);
                seen[Q] = 1'b1;
            end else if (i == 511) begin
                check9("wrap_to_000", Q, 9'h000);
            end
        end

        // Hold with en low.
        held = Q;
        for (int i = 0; i < 20; i++) cycle(1'b1, 1'b0, 1'b0, 9'h000, "hold");
        check9("hold_const", Q, held);

        // Seed load, then polynomial steps and a full period back to the seed.
        cycle(1'b1, 1'b1, 1'b0, 9'h0A5, "load_0a5");
        check9("load_0a5_const", Q, 9'h0A5);
        cycle(1'b1, 1'b0, 1'b1, 9'h000, "step_0a5");
        check9("step_0a5_const", Q, 9'h14B);
        for (int i = 2; i <= 511; i++) cycle(1'b1, 1'b0, 1'b1, 9'h000, "seed_period");
        check9("seed_wrap", Q, 9'h0A5);

        // Lock-up seed is replaced with zero.
        cycle(1'b1, 1'b1, 1'b1, 9'h1FF, "load_1ff");
        check9("load_1ff_const", Q, 9'h000);

        // Reset mid-sequence, then reset colliding with load.
        for (int i = 0; i < 37; i++) cycle(1'b1, 1'b0, 1'b1, 9'h000, "run");
        cycle(1'b0, 1'b0, 1'b1, 9'h000, "mid_reset");
        check9("mid_reset_const", Q, 9'h000);
        cycle(1'b1, 1'b0, 1'b1, 9'h000, "restart");
        check9("restart_const", Q, 9'h001);
        cycle(1'b0, 1'b1, 1'b1, 9'h0A5, "reset_vs_load");
        check9("reset_vs_load_const", Q, 9'h000);

        // Randomized mix of controls checked against the model.
        for (int i = 0; i < 1500; i++) begin
            logic       r, l, e;
            logic [8:0] s;
            r = ($urandom_range(0, 99) != 0);
            l = ($urandom_range(0, 24) == 0);
            e = ($urandom_range(0, 3) != 0);
            s = ($urandom_range(0, 7) == 0) ? 9'h1FF : 9'($urandom);
            cycle(r, l, e, s, "random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lfsr_9bit.md
Name: lfsr_9bit

Overview:
- Free-running 9-bit maximal-length XNOR Fibonacci LFSR; pseudo-random source for the Tug-of-War player-vs-computer game logic.
- The computer player compares the 9-bit output against a difficulty threshold to decide button presses.
- Sequence period is 511 states; all-ones is the only excluded (lock-up) state.
- Adds step enable, synchronous seed load and lock-up recovery; an optional period-tracking block is compiled in by macro.

Parameters:
- RESET_VALUE, 9'h000, state loaded on reset; must not be 9'h1FF.

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-low reset (asserted when 0)
- en  input  1  step enable; 1 = advance one state per cycle
- load  input  1  synchronous seed load strobe
- seed  input  9  seed value for load
- Q  output  9  current LFSR state (registered)
- period_wrap  output  1  (LFSR_PERIOD_TRACK_EN only) one-cycle pulse on sequence wrap
- step_count  output  9  (LFSR_PERIOD_TRACK_EN only) steps since last start point

Behaviour:
- Polynomial x^9 + x^5 + 1, XNOR form.
- Next state is {Q[7:0], ~(Q[8] ^ Q[4])}: shift left, feedback into bit 0.
- Priority per rising clk edge: reset low > load > en > hold.
- reset==0: Q <= RESET_VALUE (9'h000). Optional outputs clear: period_wrap=0, step_count=0.
- load==1: Q <= seed. If seed==9'h1FF, Q <= 9'h000 instead (lock-up avoidance). A load takes effect even when en==0.
- en==1 and no load: Q <= next state.
- en==0 and no load: Q holds.
- Lock-up recovery: if Q is ever 9'h1FF while stepping, the next state is forced to 9'h000.
- Latency: Q changes on the edge after the controlling inputs are sampled. No combinational path from inputs to Q.
- Sequence from 9'h000: 001, 003, 007, 00F, 01F, 03E, ...
- Period: exactly 511 steps. All 511 values other than 9'h1FF are visited once per period. State returns to the start value after step 511.
- Reset mid-sequence restarts the sequence from RESET_VALUE on that edge.

Optional Feature:
- Macro LFSR_PERIOD_TRACK_EN.
- Defined:
  - Start point = RESET_VALUE after reset, or the effective seed after load.
  - step_count increments on each enabled step; it resets to 0 on reset, on load, and on wrap.
  - period_wrap = 1 for exactly the one cycle in which the registered Q equals the start point after a nonzero step count, i.e. after 511 enabled steps.
  - period_wrap is registered and aligned with Q.
  - load or reset in the wrap cycle: the outputs clear and no pulse is produced.
- Undefined: period_wrap and step_count ports and all related logic are absent. Q behaviour is identical.

Test Plan:
- reset=0 for 1 edge, then reset=1, en=1 -> Q sequence after release: 000, 001, 003, 007, 00F, 01F, 03E.
- en=1 for 600 cycles from reset -> Q==000 again after exactly 511 steps; no value repeats within a period; 1FF never appears; with macro, period_wrap pulses once at step 511 and step_count is 0 in that cycle.
- en=0 for 20 cycles mid-sequence -> Q constant; step_count constant.
- load=1, seed=9'h0A5 -> Q=0A5 next edge; next enabled steps follow the polynomial (0A5 -> 14B); with macro, wrap occurs 511 steps later at Q=0A5.
- load=1, seed=9'h1FF -> Q=000.
- reset asserted while en=1 at an arbitrary step -> Q=000 on that edge; sequence restarts at 001; load=1 asserted together with reset=0 -> reset wins, Q=000.
